// File: rtl/dadd_rot_param.sv
// dadd_rot_param: scaled stochastic adder that picks one input stream per
// cycle in Sobol order, optionally pacing the select with an LFSR rotation.
module dadd_rot_param #(
  parameter int INUM    = 8,
  parameter int LOGINUM = 3,
  parameter int SEEDWD  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEEDWD-1:0]  iseed,
  input  logic [INUM-1:0]    in,
  output logic               out,
  output logic [LOGINUM-1:0] sel_o,
  output logic               wrap
);

  logic [LOGINUM-1:0] cnt_q, cnt_d;
  logic [SEEDWD-1:0]  lfsr_q, lfsr_d;
  logic               out_q, out_d;
  logic               wrap_q, wrap_d;
  logic [7:0]         lfsr_x;
  logic               fb;
  logic               advance;
  logic [LOGINUM-1:0] sel;

  // Bit-reversed counter gives the dimension-1 Sobol select order.
  always_comb begin
    sel = '0;
    for (int i = 0; i < LOGINUM; i++)
      sel[i] = cnt_q[LOGINUM-1-i];
  end

  // Fibonacci feedback taps for a maximal-length sequence per width.
  always_comb begin
    lfsr_x = 8'(lfsr_q);
    fb     = 1'b0;
    case (SEEDWD)
      3:       fb = lfsr_x[2] ^ lfsr_x[1];
      4:       fb = lfsr_x[3] ^ lfsr_x[2];
      5:       fb = lfsr_x[4] ^ lfsr_x[2];
      6:       fb = lfsr_x[5] ^ lfsr_x[4];
      7:       fb = lfsr_x[6] ^ lfsr_x[5];
      default: fb = lfsr_x[7] ^ lfsr_x[5] ^ lfsr_x[4] ^ lfsr_x[3];
    endcase
  end

  // Next-state: advance decided on the pre-load LFSR value; load wins over shift.
  always_comb begin
    advance = en & (~mode | (lfsr_q == SEEDWD'(1)));
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    wrap_d  = advance & (&cnt_q);
    if (advance)
      cnt_d = cnt_q + LOGINUM'(1);
    if (en)
      out_d = in[sel];
    if (load)
      lfsr_d = (iseed == '0) ? SEEDWD'(1) : iseed;
    else if (en)
      lfsr_d = {lfsr_q[SEEDWD-2:0], fb};
  end

  // State registers; the LFSR resets to 1 so it can never lock at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lfsr_q <= SEEDWD'(1);
      out_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out   = out_q;
  assign wrap  = wrap_q;
  assign sel_o = sel;

endmodule

// File: tb/tb_dadd_rot_param.sv
// tb_dadd_rot_param: table vectors plus scoreboard model for the
// rotating scaled adder, INUM=4 / SEEDWD=3.
module tb_dadd_rot_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] iseed = '0;
  logic [3:0] din = '0;
  logic       dout;
  logic [1:0] sel;
  logic       wrap;

  dadd_rot_param #(
    .INUM(4),
    .LOGINUM(2),
    .SEEDWD(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .load(load),
    .iseed(iseed),
    .in(din),
    .out(dout),
    .sel_o(sel),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       out;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] din;
    logic [1:0] sel;
    logic       out;
    logic       wrap;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sbq[$];
  vec_t tbl[10];
  int   wraps[$];

  logic [1:0] m_cnt;
  logic [2:0] m_lfsr;
  logic       m_out;
  logic       m_wrap;
  logic [2:0] succ[8];
  logic [1:0] rev[4];

  task automatic check_outs(input string name, input exp_t e);
    exp_t a;
    a = {sel, dout, wrap};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d out=%0b wrap=%0b want sel=%0d out=%0b wrap=%0b",
               name, a.sel, a.out, a.wrap, e.sel, e.out, e.wrap);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, a, e);
    end
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_lfsr = 3'd1;
    m_out  = 1'b0;
    m_wrap = 1'b0;
  endtask

  // One clock of stimulus: model predicts, pushes, edge, pop and compare.
  task automatic drive(input logic e, input logic m, input logic l,
                       input logic [2:0] s, input logic [3:0] x);
    logic adv;
    exp_t ex;
    en    = e;
    mode  = m;
    load  = l;
    iseed = s;
    din   = x;
    adv    = e && (!m || m_lfsr == 3'd1);
    m_wrap = adv && (m_cnt == 2'd3);
    if (e) m_out = x[rev[m_cnt]];
    if (adv) m_cnt = m_cnt + 2'd1;
    if (l) m_lfsr = (s == 3'd0) ? 3'd1 : s;
    else if (e) m_lfsr = succ[m_lfsr];
    sbq.push_back({rev[m_cnt], m_out, m_wrap});
    @(posedge clk);
    #1;
    ex = sbq.pop_front();
    check_outs("scoreboard", ex);
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check_outs(name, '0);
    @(posedge clk);
    #1 check_outs({name, "_hold"}, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int t0;
    int guard;
    logic [1:0] c0;
    succ[0] = 3'd0; succ[1] = 3'd2; succ[2] = 3'd5; succ[3] = 3'd7;
    succ[4] = 3'd1; succ[5] = 3'd3; succ[6] = 3'd4; succ[7] = 3'd6;
    rev[0] = 2'd0; rev[1] = 2'd2; rev[2] = 2'd1; rev[3] = 2'd3;

    tbl[0] = '{1'b1, 4'b0101, 2'd2, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4'b0101, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'b0101, 2'd3, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'b0101, 2'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'b1010, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'b1010, 2'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'b1010, 2'd3, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 4'b1000, 2'd0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 4'b0001, 2'd2, 1'b1, 1'b0};

    // Power-on reset, with en high to show reset dominates.
    #1 rst_n = 1'b0;
    #1 check_outs("reset_state", '0);
    en = 1'b1;
    din = 4'hF;
    @(posedge clk);
    #1 check_outs("reset_held", '0);
    rst_n = 1'b1;
    model_reset();

    // Mode 0 Sobol order and output pattern from hand-built vectors.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].en, 1'b0, 1'b0, 3'd0, tbl[i].din);
      check_outs($sformatf("table_%0d", i),
                 {tbl[i].sel, tbl[i].out, tbl[i].wrap});
    end

    // Async reset mid-stream, then the sequence restarts at sel 0.
    async_reset("async_rst");
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'b0101);
    check_outs("restart", {2'd2, 1'b1, 1'b0});

    // Mode 1: advance once per 7-cycle LFSR period, wrap every 28.
    async_reset("rst_mode1");
    wraps.delete();
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b0011);
      if (wrap) wraps.push_back(i);
    end
    check_int("mode1_wrap_count", wraps.size(), 2);
    if (wraps.size() >= 2) begin
      check_int("mode1_first_wrap", wraps[0], 21);
      check_int("mode1_wrap_interval", wraps[1] - wraps[0], 28);
    end

    // Load on a rotation tick: advance uses the old value, seed 5 takes over.
    guard = 0;
    while (m_lfsr != 3'd1 && guard < 10) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b1100);
      guard++;
    end
    check_int("lfsr_reached_one", int'(m_lfsr), 1);
    c0 = m_cnt;
    drive(1'b1, 1'b1, 1'b1, 3'd5, 4'b1100);
    check_int("load_cycle_adv", int'(sel), int'(rev[c0 + 2'd1]));
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b1100);
    check_int("seed5_wait", int'(sel), int'(rev[c0 + 2'd1]));
    drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b1100);
    check_int("seed5_resume", int'(sel), int'(rev[c0 + 2'd2]));

    // Zero seed loads as 1, so the next mode-1 cycle advances.
    drive(1'b1, 1'b1, 1'b1, 3'd0, 4'b0110);
    c0 = m_cnt;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b0110);
    check_int("zero_seed_adv", int'(sel), int'(rev[c0 + 2'd1]));

    // Frozen while en is low, with a load pulsed in the middle.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'b1111);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'b0, (i == 4), 3'd6, 4'($urandom));
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b1001);

    // Random traffic including mode flips and loads.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 7) != 0), 1'($urandom),
            ($urandom_range(0, 15) == 0), 3'($urandom), 4'($urandom));

    async_reset("rst_final");
    drive(1'b1, 1'b1, 1'b0, 3'd0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
